// File: rtl/nibble_pkg.sv
// Shared types and constants for the digit-serial nibble adder.
// Optional decimal mode is enabled by defining NIBBLE_BCD_EN.
package nibble_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [3:0]  BCD_ADJ = 4'd6;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef NIBBLE_BCD_EN
  // Nine's complement of one decimal digit; non-decimal digits simply wrap.
  function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] d);
    return DIGIT_W'(BCD_MAX - d);
  endfunction
`endif

endpackage

// File: rtl/nibble_digit_add.sv
// Combinational single-digit adder with carry in/out.
// With NIBBLE_BCD_EN defined, an extra i_bcd input applies the decimal adjust.
module nibble_digit_add
  import nibble_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_cin,
`ifdef NIBBLE_BCD_EN
  input  logic               i_bcd,
`endif
  output logic [DIGIT_W-1:0] o_s,
  output logic               o_cout
);

  logic [DIGIT_W:0] w_raw;

  // Raw binary digit sum, optionally decimal-adjusted when it exceeds nine.
  always_comb begin
    w_raw  = {1'b0, i_a} + {1'b0, i_b} + (DIGIT_W+1)'(i_cin);
    o_s    = w_raw[DIGIT_W-1:0];
    o_cout = w_raw[DIGIT_W];
`ifdef NIBBLE_BCD_EN
    if (i_bcd && (w_raw > (DIGIT_W+1)'(BCD_MAX))) begin
      o_s    = DIGIT_W'(w_raw[DIGIT_W-1:0] + BCD_ADJ);
      o_cout = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Digit-serial adder/subtractor: one 4-bit digit per clock, LSB digit first,
// valid/ready on both operand and result sides.
// Define NIBBLE_BCD_EN to add the bcd input and decimal-mode arithmetic.
module nibble_serial_adder
  import nibble_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef NIBBLE_BCD_EN
  input  logic             bcd,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NUM_DIGITS = WIDTH / DIGIT_W;
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;
`ifdef NIBBLE_BCD_EN
  logic               r_bcd;
`endif

  logic [WIDTH-1:0]   w_b_eff;
  logic [DIGIT_W-1:0] w_a_dig;
  logic [DIGIT_W-1:0] w_b_dig;
  logic [DIGIT_W-1:0] w_s;
  logic               w_c;
  logic               w_ovf;

  // Effective B operand as latched: inverted for binary subtract, nine's complement for decimal.
  always_comb begin
    w_b_eff = sub ? ~b : b;
`ifdef NIBBLE_BCD_EN
    if (bcd && sub) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        w_b_eff[d*DIGIT_W +: DIGIT_W] = nines_comp(b[d*DIGIT_W +: DIGIT_W]);
      end
    end
`endif
  end

  // Select the operand digits addressed by the current index.
  always_comb begin
    w_a_dig = '0;
    w_b_dig = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_idx == IDX_W'(d)) begin
        w_a_dig = r_a[d*DIGIT_W +: DIGIT_W];
        w_b_dig = r_b[d*DIGIT_W +: DIGIT_W];
      end
    end
  end

  nibble_digit_add u_digit (
    .i_a    (w_a_dig),
    .i_b    (w_b_dig),
    .i_cin  (r_carry),
`ifdef NIBBLE_BCD_EN
    .i_bcd  (r_bcd),
`endif
    .o_s    (w_s),
    .o_cout (w_c)
  );

  // Signed overflow from the operand sign bits and the sign of the final digit.
  always_comb begin
    w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[DIGIT_W-1] != r_a[WIDTH-1]);
`ifdef NIBBLE_BCD_EN
    if (r_bcd) begin
      w_ovf = 1'b0;
    end
`endif
  end

  // Control FSM with operand, result and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef NIBBLE_BCD_EN
      r_bcd       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= w_b_eff;
            r_carry    <= sub;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
`ifdef NIBBLE_BCD_EN
            r_bcd      <= bcd;
`endif
            r_state    <= RUN;
          end
        end
        RUN: begin
          for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_idx == IDX_W'(d)) begin
              r_sum[d*DIGIT_W +: DIGIT_W] <= w_s;
            end
          end
          r_carry <= w_c;
          r_idx   <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            r_cout      <= w_c;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
